battleship_game_ctrl: RTL and testbench
=======================================

Name: battleship_game_ctrl

Overview:
Game sequencer for the 5x5 battleship datapath. Drives two board instances, player board P and CPU board C, through placement and alternating shot turns. It validates every move against the board vectors, generates CPU moves from an LFSR, enforces a per-turn timeout, and declares win/lose. Sits between the debounced button/switch front end and the two board instances.

Parameters:
N_SHIPS, 4, ships placed per side (1..15).
TURN_CYCLES, 32'd250_000_000, player turn timeout in clk cycles (5 s at 50 MHz).
CPU_DELAY, 16'd1000, idle cycles before CPU acts in C_TURN.
LFSR_SEED, 8'hA5, non-zero LFSR reset value.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins or restarts a game from IDLE/WIN/LOSE
confirm  in  1  one-cycle pulse; player commits sel_row/sel_col
sel_row  in  3  player-selected row
sel_col  in  3  player-selected column
board_p  in  50  P board vector, 2 bits/cell at row*10+col*2 (bit0 ship, bit1 shot)
board_c  in  50  C board vector, same encoding
row  out  3  target row for the pulsed board
col  out  3  target column for the pulsed board
assign_p  out  1  one-cycle ship-assign pulse to P
assign_c  out  1  one-cycle ship-assign pulse to C
shoot_p  out  1  one-cycle shoot pulse to P (CPU fires)
shoot_c  out  1  one-cycle shoot pulse to C (player fires)
phase  out  3  0 IDLE, 1 PLACE_P, 2 PLACE_C, 3 P_TURN, 4 C_TURN, 5 CHECK, 6 WIN, 7 LOSE
reject  out  1  one-cycle pulse when a player move is refused
ships_left_p  out  4  N_SHIPS minus hits on P
ships_left_c  out  4  N_SHIPS minus hits on C

Behaviour:
- Reset: phase=IDLE; row=col=0; all pulses, reject=0; ships_left_p/c=N_SHIPS; placed counter 0; timer 0; LFSR=LFSR_SEED. Reset mid-game aborts immediately and issues no pulses.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every cycle outside reset. Candidate row=lfsr[2:0], col=lfsr[5:3].
- Valid cell: row<=4 and col<=4. Index idx=row*10+col*2, computed in 6 bits.
- IDLE/WIN/LOSE: start -> PLACE_P and clears counters. confirm is ignored in these states.
- PLACE_P, on confirm:
  - Reject if the cell is invalid or board_p[idx]=1.
  - Otherwise drive row/col, pulse assign_p next cycle, and increment placed.
  - When placed=N_SHIPS -> PLACE_C with placed cleared.
- PLACE_C: each cycle, test the LFSR candidate on board_c.
  - Invalid or occupied: retry on the next cycle.
  - Otherwise pulse assign_c and increment placed. The next candidate is evaluated no earlier than 2 cycles later so the board update is visible.
  - placed=N_SHIPS -> P_TURN.
- P_TURN: timer counts up from 0.
  - confirm on a valid cell with board_c[idx+1]=0: pulse shoot_c, go to CHECK(ret=C_TURN), timer clears.
  - Invalid or already-shot cell: reject pulse, stay in P_TURN, timer keeps running.
  - timer reaches TURN_CYCLES-1: auto-fire uses the LFSR candidate with the same validity/unshot retry as PLACE_C. confirm is ignored once auto-fire starts.
- C_TURN: wait CPU_DELAY cycles, then select a candidate with board_p[idx+1]=0 using the same retry rule. Pulse shoot_p, then CHECK(ret=P_TURN).
- CHECK: entered the cycle after a shoot pulse; holds 1 extra cycle, then samples the boards.
  - Hits = popcount over 25 cells of (ship & shot). ships_left_x = N_SHIPS - hits, 4-bit and never negative.
  - ships_left_c=0 -> WIN. Else ships_left_p=0 -> LOSE. Else -> ret state.
- Pulses: at most one of assign_p, assign_c, shoot_p, shoot_c is high in any cycle, and each is exactly one cycle wide. row/col are stable during the pulse cycle.
- Simultaneous start and confirm: start wins only in IDLE/WIN/LOSE. start elsewhere is ignored.
- Turn order: player always moves first after placement.

Test Plan:
- Reset mid-P_TURN (rst_n low 3 cycles) -> phase=0, ships_left_p=ships_left_c=N_SHIPS, no pulses while low or on release.
- N_SHIPS=2: start, confirm (0,0), confirm (0,0), confirm (4,4) -> assign_p for (0,0), reject on the duplicate, assign_p for (4,4), then phase=2; exactly 2 assign_c pulses at distinct valid cells, then phase=3.
- Player confirms (5,1) then (1,1) in P_TURN -> reject pulse with no shoot_c; then shoot_c at row=1, col=1, phase goes 5 -> 4, and shoot_p follows CPU_DELAY+retry cycles later.
- TURN_CYCLES=10, no confirm -> shoot_c auto-issued at an unshot valid cell 10-11+retry cycles after P_TURN entry.
- Force board_c with both C ships already marked shot, then player fires -> CHECK yields ships_left_c=0 and phase=6; later confirms are ignored; start returns phase to 1.
- Preset board_p with both P ships hit after the CPU shot -> phase=7 (LOSE) and ships_left_p=0.

Source files
------------

// File: rtl/battleship_game_ctrl.sv
// Game sequencer for the 5x5 battleship datapath: placement, alternating
// shot turns, LFSR-driven CPU moves, player turn timeout and win/lose.
module battleship_game_ctrl #(
    parameter int unsigned N_SHIPS     = 4,
    parameter logic [31:0] TURN_CYCLES = 32'd250_000_000,
    parameter logic [15:0] CPU_DELAY   = 16'd1000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        confirm,
    input  logic [2:0]  sel_row,
    input  logic [2:0]  sel_col,
    input  logic [49:0] board_p,
    input  logic [49:0] board_c,
    output logic [2:0]  row,
    output logic [2:0]  col,
    output logic        assign_p,
    output logic        assign_c,
    output logic        shoot_p,
    output logic        shoot_c,
    output logic [2:0]  phase,
    output logic        reject,
    output logic [3:0]  ships_left_p,
    output logic [3:0]  ships_left_c
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLACE_P = 3'd1,
        S_PLACE_C = 3'd2,
        S_P_TURN  = 3'd3,
        S_C_TURN  = 3'd4,
        S_CHECK   = 3'd5,
        S_WIN     = 3'd6,
        S_LOSE    = 3'd7
    } state_t;

    localparam logic [3:0]  SHIPS        = 4'(N_SHIPS);
    localparam logic [31:0] TIMEOUT_LAST = TURN_CYCLES - 32'd1;
    localparam logic [31:0] CPU_WAIT     = {16'h0000, CPU_DELAY};

    // Cell lies inside the 5x5 grid.
    function automatic logic cell_valid(input logic [2:0] r, input logic [2:0] c);
        return (r <= 3'd4) && (c <= 3'd4);
    endfunction

    // One bit of a cell: shot=0 selects the ship bit, shot=1 the shot bit.
    function automatic logic cell_bit(input logic [49:0] b, input logic [2:0] r,
                                      input logic [2:0] c, input logic shot);
        logic [5:0] idx;
        idx = ({3'b000, r} * 6'd10) + {2'b00, c, 1'b0} + {5'b00000, shot};
        return 1'(b >> idx);
    endfunction

    // Ships remaining = N_SHIPS minus cells that are both ship and shot, floored at 0.
    function automatic logic [3:0] ships_left(input logic [49:0] b);
        logic [4:0] hits;
        hits = 5'd0;
        for (int i = 0; i < 25; i++) begin
            hits = hits + {4'b0000, b[2*i] & b[2*i+1]};
        end
        if (hits >= {1'b0, SHIPS}) begin
            return 4'd0;
        end else begin
            return SHIPS - hits[3:0];
        end
    endfunction

    state_t      r_state, r_ret;
    logic [2:0]  r_row, r_col;
    logic        r_assign_p, r_assign_c, r_shoot_p, r_shoot_c, r_reject;
    logic [3:0]  r_left_p, r_left_c, r_placed;
    logic [31:0] r_timer;
    logic [7:0]  r_lfsr;
    logic [1:0]  r_hold;
    logic        r_auto, r_pend, r_chk;

    state_t      w_state, w_ret;
    logic [2:0]  w_row, w_col;
    logic        w_assign_p, w_assign_c, w_shoot_p, w_shoot_c, w_reject;
    logic [3:0]  w_left_p, w_left_c, w_placed;
    logic [31:0] w_timer;
    logic [1:0]  w_hold;
    logic        w_auto, w_pend, w_chk;

    logic [2:0]  w_cand_row, w_cand_col;
    logic        w_cand_ok, w_sel_ok, w_lfsr_fb;
    logic        w_sel_p_ship, w_sel_c_shot, w_cand_c_ship, w_cand_c_shot, w_cand_p_shot;
    logic [3:0]  w_count_p, w_count_c, w_placed_inc;

    assign w_lfsr_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_cand_row    = r_lfsr[2:0];
    assign w_cand_col    = r_lfsr[5:3];
    assign w_cand_ok     = cell_valid(w_cand_row, w_cand_col);
    assign w_sel_ok      = cell_valid(sel_row, sel_col);
    assign w_sel_p_ship  = cell_bit(board_p, sel_row, sel_col, 1'b0);
    assign w_sel_c_shot  = cell_bit(board_c, sel_row, sel_col, 1'b1);
    assign w_cand_c_ship = cell_bit(board_c, w_cand_row, w_cand_col, 1'b0);
    assign w_cand_c_shot = cell_bit(board_c, w_cand_row, w_cand_col, 1'b1);
    assign w_cand_p_shot = cell_bit(board_p, w_cand_row, w_cand_col, 1'b1);
    assign w_count_p     = ships_left(board_p);
    assign w_count_c     = ships_left(board_c);
    assign w_placed_inc  = r_placed + 4'd1;

    // Next-state, next-output and counter logic for the game sequencer.
    always_comb begin
        w_state    = r_state;
        w_ret      = r_ret;
        w_row      = r_row;
        w_col      = r_col;
        w_assign_p = 1'b0;
        w_assign_c = 1'b0;
        w_shoot_p  = 1'b0;
        w_shoot_c  = 1'b0;
        w_reject   = 1'b0;
        w_left_p   = r_left_p;
        w_left_c   = r_left_c;
        w_placed   = r_placed;
        w_timer    = r_timer;
        w_hold     = r_hold;
        w_auto     = r_auto;
        w_pend     = r_pend;
        w_chk      = r_chk;
        case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    w_state  = S_PLACE_P;
                    w_placed = 4'd0;
                    w_timer  = 32'd0;
                    w_left_p = SHIPS;
                    w_left_c = SHIPS;
                    w_hold   = 2'd0;
                    w_auto   = 1'b0;
                    w_pend   = 1'b0;
                    w_chk    = 1'b0;
                end else begin
                    w_state = r_state;
                end
            end
            S_PLACE_P: begin
                if (!confirm) begin
                    w_state = r_state;
                end else if (!w_sel_ok || w_sel_p_ship) begin
                    w_reject = 1'b1;
                end else begin
                    w_row      = sel_row;
                    w_col      = sel_col;
                    w_assign_p = 1'b1;
                    if (w_placed_inc == SHIPS) begin
                        w_state  = S_PLACE_C;
                        w_placed = 4'd0;
                        w_hold   = 2'd0;
                    end else begin
                        w_placed = w_placed_inc;
                    end
                end
            end
            S_PLACE_C: begin
                if (r_hold != 2'd0) begin
                    // Give the board one full cycle to absorb the last assign.
                    w_hold = r_hold - 2'd1;
                end else if (w_cand_ok && !w_cand_c_ship) begin
                    w_row      = w_cand_row;
                    w_col      = w_cand_col;
                    w_assign_c = 1'b1;
                    w_hold     = 2'd2;
                    if (w_placed_inc == SHIPS) begin
                        w_state  = S_P_TURN;
                        w_placed = 4'd0;
                        w_timer  = 32'd0;
                        w_auto   = 1'b0;
                        w_pend   = 1'b0;
                    end else begin
                        w_placed = w_placed_inc;
                    end
                end else begin
                    w_hold = 2'd0;
                end
            end
            S_P_TURN: begin
                if (r_pend) begin
                    // Shoot pulse just went out; CHECK starts the cycle after it.
                    w_state = S_CHECK;
                    w_pend  = 1'b0;
                    w_chk   = 1'b0;
                end else if (r_auto || (r_timer == TIMEOUT_LAST)) begin
                    w_auto = 1'b1;
                    if (w_cand_ok && !w_cand_c_shot) begin
                        w_row     = w_cand_row;
                        w_col     = w_cand_col;
                        w_shoot_c = 1'b1;
                        w_pend    = 1'b1;
                        w_ret     = S_C_TURN;
                        w_timer   = 32'd0;
                        w_auto    = 1'b0;
                    end else begin
                        w_timer = r_timer;
                    end
                end else if (confirm) begin
                    if (w_sel_ok && !w_sel_c_shot) begin
                        w_row     = sel_row;
                        w_col     = sel_col;
                        w_shoot_c = 1'b1;
                        w_pend    = 1'b1;
                        w_ret     = S_C_TURN;
                        w_timer   = 32'd0;
                    end else begin
                        w_reject = 1'b1;
                        w_timer  = r_timer + 32'd1;
                    end
                end else begin
                    w_timer = r_timer + 32'd1;
                end
            end
            S_C_TURN: begin
                if (r_pend) begin
                    w_state = S_CHECK;
                    w_pend  = 1'b0;
                    w_chk   = 1'b0;
                end else if (r_timer < CPU_WAIT) begin
                    w_timer = r_timer + 32'd1;
                end else if (w_cand_ok && !w_cand_p_shot) begin
                    w_row     = w_cand_row;
                    w_col     = w_cand_col;
                    w_shoot_p = 1'b1;
                    w_pend    = 1'b1;
                    w_ret     = S_P_TURN;
                    w_timer   = 32'd0;
                end else begin
                    w_timer = r_timer;
                end
            end
            S_CHECK: begin
                if (!r_chk) begin
                    w_chk = 1'b1;
                end else begin
                    w_chk    = 1'b0;
                    w_left_p = w_count_p;
                    w_left_c = w_count_c;
                    w_timer  = 32'd0;
                    w_auto   = 1'b0;
                    if (w_count_c == 4'd0) begin
                        w_state = S_WIN;
                    end else if (w_count_p == 4'd0) begin
                        w_state = S_LOSE;
                    end else begin
                        w_state = r_ret;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State, registered outputs and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ret      <= S_P_TURN;
            r_row      <= 3'd0;
            r_col      <= 3'd0;
            r_assign_p <= 1'b0;
            r_assign_c <= 1'b0;
            r_shoot_p  <= 1'b0;
            r_shoot_c  <= 1'b0;
            r_reject   <= 1'b0;
            r_left_p   <= SHIPS;
            r_left_c   <= SHIPS;
            r_placed   <= 4'd0;
            r_timer    <= 32'd0;
            r_hold     <= 2'd0;
            r_auto     <= 1'b0;
            r_pend     <= 1'b0;
            r_chk      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_ret      <= w_ret;
            r_row      <= w_row;
            r_col      <= w_col;
            r_assign_p <= w_assign_p;
            r_assign_c <= w_assign_c;
            r_shoot_p  <= w_shoot_p;
            r_shoot_c  <= w_shoot_c;
            r_reject   <= w_reject;
            r_left_p   <= w_left_p;
            r_left_c   <= w_left_c;
            r_placed   <= w_placed;
            r_timer    <= w_timer;
            r_hold     <= w_hold;
            r_auto     <= w_auto;
            r_pend     <= w_pend;
            r_chk      <= w_chk;
        end
    end

    // Free-running CPU move generator (taps 8,6,5,4).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    assign row          = r_row;
    assign col          = r_col;
    assign assign_p     = r_assign_p;
    assign assign_c     = r_assign_c;
    assign shoot_p      = r_shoot_p;
    assign shoot_c      = r_shoot_c;
    assign reject       = r_reject;
    assign phase        = r_state;
    assign ships_left_p = r_left_p;
    assign ships_left_c = r_left_c;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Bench for battleship_game_ctrl: the bench plays both board instances,
// drives directed and random moves, and checks against a cell-level model.
module tb_battleship_game_ctrl;
    localparam int          NS = 2;
    localparam logic [31:0] TC = 32'd10;
    localparam logic [15:0] CD = 16'd6;

    logic        clk = 1'b0;
    logic        rst_n, start, confirm;
    logic [2:0]  sel_row, sel_col, row, col, phase;
    logic [49:0] bp, bc;
    logic        assign_p, assign_c, shoot_p, shoot_c, reject;
    logic [3:0]  ships_left_p, ships_left_c;

    int total = 0, bad = 0, cyc = 0, viol = 0;
    int n_ap = 0, n_ac = 0, n_sp = 0, n_sc = 0;
    int sc_cyc = 0, sp_cyc = 0;
    logic [2:0] sc_r, sc_c, sp_r, sp_c;
    logic sc_prev, sp_prev;
    logic [2:0] ac_r[$], ac_c[$];
    logic pend_ap = 1'b0, pend_ac = 1'b0, pend_sp = 1'b0, pend_sc = 1'b0;
    logic [2:0] pend_r = 3'd0, pend_c = 3'd0;

    always #5 clk = ~clk;

    battleship_game_ctrl #(.N_SHIPS(NS), .TURN_CYCLES(TC), .CPU_DELAY(CD), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .confirm(confirm),
        .sel_row(sel_row), .sel_col(sel_col), .board_p(bp), .board_c(bc),
        .row(row), .col(col), .assign_p(assign_p), .assign_c(assign_c),
        .shoot_p(shoot_p), .shoot_c(shoot_c), .phase(phase), .reject(reject),
        .ships_left_p(ships_left_p), .ships_left_c(ships_left_c));

    function automatic int bidx(int r, int c);
        return r * 10 + c * 2;
    endfunction

    function automatic logic valid(int r, int c);
        return (r >= 0) && (r <= 4) && (c >= 0) && (c <= 4);
    endfunction

    // Model: ships left = N minus cells that are both ship and shot, floored at 0.
    function automatic int left_of(logic [49:0] b);
        int h = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (b[bidx(r, c)] && b[bidx(r, c) + 1]) h++;
        return (h >= NS) ? 0 : NS - h;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: boards latch the pulses of the cycle just ended, then log the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (pend_ap) bp[bidx(int'(pend_r), int'(pend_c))] = 1'b1;
        if (pend_ac) bc[bidx(int'(pend_r), int'(pend_c))] = 1'b1;
        if (pend_sp) bp[bidx(int'(pend_r), int'(pend_c)) + 1] = 1'b1;
        if (pend_sc) bc[bidx(int'(pend_r), int'(pend_c)) + 1] = 1'b1;
        pend_ap = assign_p; pend_ac = assign_c; pend_sp = shoot_p; pend_sc = shoot_c;
        pend_r = row; pend_c = col;
        if (int'(assign_p) + int'(assign_c) + int'(shoot_p) + int'(shoot_c) > 1) viol++;
        if (assign_p) n_ap++;
        if (assign_c) begin n_ac++; ac_r.push_back(row); ac_c.push_back(col); end
        if (shoot_c) begin
            n_sc++; sc_cyc = cyc; sc_r = row; sc_c = col;
            sc_prev = bc[bidx(int'(row), int'(col)) + 1];
        end
        if (shoot_p) begin
            n_sp++; sp_cyc = cyc; sp_r = row; sp_c = col;
            sp_prev = bp[bidx(int'(row), int'(col)) + 1];
        end
    endtask

    task automatic wait_phase(input string tag, input logic [2:0] ph, input int budget);
        int n = 0;
        while (phase !== ph && n < budget) begin tick(); n++; end
        chk(tag, phase, ph);
    endtask

    task automatic press(input int r, input int c);
        sel_row = 3'(r); sel_col = 3'(c); confirm = 1'b1;
        tick();
        confirm = 1'b0;
    endtask

    initial begin
        int n0, lat, entry, placed, iter, r, c, k, snap, fr, fc;
        logic exp_ok;
        rst_n = 1'b0; start = 1'b0; confirm = 1'b0; sel_row = 3'd0; sel_col = 3'd0;
        bp = 50'd0; bc = 50'd0;
        repeat (3) tick();
        chk("reset_phase", phase, 0);
        chk("reset_left_p", ships_left_p, NS);
        chk("reset_left_c", ships_left_c, NS);
        chk("reset_rowcol", {row, col}, 0);
        chk("reset_pulses", {assign_p, assign_c, shoot_p, shoot_c, reject}, 0);
        rst_n = 1'b1;
        tick();
        press(1, 1);
        chk("idle_confirm_ignored", {phase, assign_p, reject}, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_to_place_p", phase, 1);

        // Directed placement: (0,0), duplicate (0,0), (4,4).
        press(0, 0);
        chk("place_00", {assign_p, row, col}, {1'b1, 3'd0, 3'd0});
        tick(); tick();
        press(0, 0);
        chk("place_dup_reject", {reject, assign_p}, 2'b10);
        tick();
        press(4, 4);
        chk("place_44", {assign_p, row, col, phase}, {1'b1, 3'd4, 3'd4, 3'd2});
        wait_phase("place_c_done", 3'd3, 100);
        chk("assign_c_count", n_ac, 2);
        chk("assign_c_valid", valid(int'(ac_r[0]), int'(ac_c[0])) && valid(int'(ac_r[1]), int'(ac_c[1])), 1);
        chk("assign_c_distinct", {ac_r[0], ac_c[0]} != {ac_r[1], ac_c[1]}, 1);

        // Player turn: invalid cell then a good one.
        n0 = n_sc;
        press(5, 1);
        chk("turn_invalid_reject", {reject, shoot_c}, 2'b10);
        press(1, 1);
        chk("turn_shoot_11", {shoot_c, row, col}, {1'b1, 3'd1, 3'd1});
        chk("turn_one_shot", n_sc, n0 + 1);
        wait_phase("check_after_player", 3'd5, 3);
        wait_phase("to_c_turn", 3'd4, 4);
        chk("left_c_after_player", ships_left_c, left_of(bc));
        entry = cyc;
        n0 = n_sp;
        for (int i = 0; i < int'(CD) + 60 && n_sp == n0; i++) tick();
        chk("cpu_shot_seen", n_sp, n0 + 1);
        lat = sp_cyc - entry;
        chk("cpu_delay_window", (lat >= int'(CD) + 1) && (lat <= int'(CD) + 41), 1);
        chk("cpu_cell_ok", {valid(int'(sp_r), int'(sp_c)), sp_prev}, 2'b10);
        wait_phase("back_to_p_turn", 3'd3, 10);
        chk("left_p_after_cpu", ships_left_p, left_of(bp));

        // Timeout auto-fire with no player input.
        entry = cyc;
        n0 = n_sc;
        for (int i = 0; i < 60 && n_sc == n0; i++) tick();
        chk("autofire_seen", n_sc, n0 + 1);
        lat = sc_cyc - entry;
        chk("autofire_window", (lat >= int'(TC)) && (lat <= int'(TC) + 40), 1);
        chk("autofire_cell_ok", {valid(int'(sc_r), int'(sc_c)), sc_prev}, 2'b10);
        wait_phase("auto_to_c_turn", 3'd4, 6);
        wait_phase("auto_back_p_turn", 3'd3, int'(CD) + 80);

        // Win: every C ship already shot, player fires at any unshot cell.
        for (int i = 0; i < 25; i++)
            if (bc[2 * i]) bc[2 * i + 1] = 1'b1;
        fr = 0; fc = 0;
        for (int i = 24; i >= 0; i--)
            if (!bc[2 * i + 1]) begin fr = i / 5; fc = i % 5; end
        press(fr, fc);
        chk("win_shot", {shoot_c, row, col}, {1'b1, 3'(fr), 3'(fc)});
        wait_phase("win_phase", 3'd6, 8);
        chk("win_left_c", ships_left_c, left_of(bc));
        chk("win_left_c_zero", ships_left_c, 0);
        press(2, 2);
        chk("win_confirm_ignored", {phase, shoot_c, assign_p, reject}, {3'd6, 3'b000});
        start = 1'b1; sel_row = 3'd2; sel_col = 3'd2; confirm = 1'b1;
        bp = 50'd0; bc = 50'd0;
        tick();
        start = 1'b0; confirm = 1'b0;
        chk("restart_start_wins", {phase, assign_p}, {3'd1, 1'b0});
        chk("restart_left", {ships_left_p, ships_left_c}, {4'(NS), 4'(NS)});

        // Random placement against the model.
        placed = 0; iter = 0;
        while (placed < NS && iter < 60) begin
            r = $urandom_range(0, 5); c = $urandom_range(0, 5);
            exp_ok = valid(r, c) && !bp[bidx(r, c)];
            press(r, c);
            if (exp_ok) begin
                chk("rand_place_assign", {assign_p, reject, row, col}, {2'b10, 3'(r), 3'(c)});
                placed++;
            end else begin
                chk("rand_place_reject", {reject, assign_p}, 2'b10);
            end
            tick(); tick();
            iter++;
        end
        chk("rand_place_count", placed, NS);
        wait_phase("place_c_done2", 3'd3, 100);

        // Player misses, then both P ships are preset hit before the CPU shot.
        k = $urandom_range(0, 24);
        fr = 0; fc = 0;
        for (int j = 24; j >= 0; j--) begin
            int m;
            m = (k + j) % 25;
            if (!bc[2 * m] && !bc[2 * m + 1]) begin fr = m / 5; fc = m % 5; end
        end
        press(fr, fc);
        chk("miss_shot", {shoot_c, row, col}, {1'b1, 3'(fr), 3'(fc)});
        wait_phase("miss_to_c_turn", 3'd4, 6);
        chk("miss_left_c", ships_left_c, left_of(bc));
        for (int i = 0; i < 25; i++)
            if (bp[2 * i]) bp[2 * i + 1] = 1'b1;
        wait_phase("lose_phase", 3'd7, int'(CD) + 80);
        chk("lose_left_p", ships_left_p, left_of(bp));
        chk("lose_left_p_zero", ships_left_p, 0);

        // Reset in the middle of a player turn.
        bp = 50'd0; bc = 50'd0;
        start = 1'b1; tick(); start = 1'b0;
        press(2, 2); tick(); tick();
        press(3, 3);
        wait_phase("rst_setup_p_turn", 3'd3, 100);
        snap = n_ap + n_ac + n_sp + n_sc;
        rst_n = 1'b0;
        #1;
        chk("rst_async_phase", phase, 0);
        repeat (3) begin
            tick();
            chk("rst_low_quiet", {phase, assign_p, assign_c, shoot_p, shoot_c, reject}, 0);
        end
        rst_n = 1'b1;
        tick(); tick();
        chk("rst_release_phase", phase, 0);
        chk("rst_release_left", {ships_left_p, ships_left_c}, {4'(NS), 4'(NS)});
        chk("rst_no_pulses", n_ap + n_ac + n_sp + n_sc, snap);
        chk("pulse_onehot", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
